output_pool_stage: RTL and testbench

Streaming 2x2/stride-2 max-pooling stage between the convolution controller's result stream and the output SRAM write port. It accepts one signed 32-bit conv result per cycle in row-major order for one output channel tile and emits pooled values, or passes them through unchanged when pooling is disabled. A single-entry output register holds results until the output SRAM writer accepts them. `done` pulses once per tile so `transfer_controller` can sequence the next tile.

---
 rtl/output_pool_stage.sv | 127 ++++++++++++
 tb/tb_output_pool_stage.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/output_pool_stage.sv
// Streaming 2x2/stride-2 signed max-pool (or bypass) between the conv result
// stream and the output SRAM writer, with a single-entry output register.
module output_pool_stage #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned MAX_W  = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [6:0]        map_w,
  input  logic [6:0]        map_h,
  input  logic              pool_en,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  input  logic              out_ready,
  output logic              busy,
  output logic              done
);

  localparam int unsigned DIM_W = 7;
  localparam int unsigned COL_W = $clog2(MAX_W);
  localparam int unsigned ROW_W = 6;
  localparam int unsigned LB_D  = MAX_W / 2;
  localparam int unsigned K_W   = COL_W - 1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_t;

  state_t state, state_next;

  logic [DIM_W-1:0]         map_w_q, map_h_q;
  logic                     pool_en_q;
  logic [COL_W-1:0]         col;
  logic [ROW_W-1:0]         row;
  logic signed [DATA_W-1:0] hold;
  logic signed [DATA_W-1:0] line_buf [LB_D];

  logic                     accept, last_col, last_row, load;
  logic [K_W-1:0]           k;
  logic signed [DATA_W-1:0] din_s, pair_max, quad_max, lb_rd, load_val;

  assign accept   = in_valid && in_ready;
  assign last_col = (DIM_W'(col) == map_w_q - DIM_W'(1));
  assign last_row = (DIM_W'(row) == map_h_q - DIM_W'(1));
  assign k        = col[COL_W-1:1];
  assign din_s    = $signed(in_data);
  assign lb_rd    = line_buf[k];
  assign pair_max = (din_s > hold) ? din_s : hold;
  assign quad_max = (pair_max > lb_rd) ? pair_max : lb_rd;
  // Pool mode completes a window on the odd-column pixel of an odd row.
  assign load     = accept && (!pool_en_q || (col[0] && row[0]));
  assign load_val = pool_en_q ? quad_max : din_s;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_next;
  end

  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    done       = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) state_next = S_RUN;
      end
      S_RUN: begin
        in_ready = !(out_valid && !out_ready);
        if (in_valid && in_ready && last_col && last_row) state_next = S_DRAIN;
      end
      S_DRAIN: begin
        if (!out_valid || out_ready) begin
          done       = 1'b1;
          state_next = S_IDLE;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  // Config, counters, hold register and output register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy      <= 1'b0;
      map_w_q   <= '0;
      map_h_q   <= '0;
      pool_en_q <= 1'b0;
      col       <= '0;
      row       <= '0;
      hold      <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
    end else begin
      busy <= (state_next != S_IDLE);
      if (state == S_IDLE && start) begin
        map_w_q   <= map_w;
        map_h_q   <= map_h;
        pool_en_q <= pool_en;
        col       <= '0;
        row       <= '0;
      end
      if (accept) begin
        if (last_col) begin
          col <= '0;
          row <= row + ROW_W'(1);
        end else begin
          col <= col + COL_W'(1);
        end
        if (pool_en_q && !col[0]) hold <= din_s;
      end
      if (load) begin
        out_valid <= 1'b1;
        out_data  <= load_val;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

  // Line buffer holds the even-row pair maxima; always written before read.
  always_ff @(posedge clk) begin
    if (accept && pool_en_q && col[0] && !row[0]) line_buf[k] <= pair_max;
  end

endmodule

// File: tb/tb_output_pool_stage.sv
// Directed bench for output_pool_stage: pool, signed, odd size, backpressure,
// bypass and mid-tile reset.
module tb_output_pool_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [6:0]  map_w, map_h;
  logic        pool_en;
  logic        in_valid;
  logic [31:0] in_data;
  logic        in_ready;
  logic        out_valid;
  logic [31:0] out_data;
  logic        out_ready;
  logic        busy;
  logic        done;

  output_pool_stage #(.DATA_W(32), .MAX_W(64)) dut (
    .clk(clk), .rst(rst), .start(start), .map_w(map_w), .map_h(map_h),
    .pool_en(pool_en), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .out_valid(out_valid), .out_data(out_data),
    .out_ready(out_ready), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  int     vals[$];
  longint exp_q[$];
  longint got_q[$];
  int     acc_cyc_q[$];
  int     out_cyc_q[$];
  int     n_done, done_cyc, bp_err, hold_err, stall_cnt;
  bit     timed_out;

  task automatic check(input string tag, input longint got, input longint exp);
    n_tests++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic run_tile(input int w, input int h, input bit pool, input bit bp);
    int  idx, n, cyc_i;
    bit  prev_stall;
    logic [31:0] prev_data;
    n = w * h;
    got_q.delete(); acc_cyc_q.delete(); out_cyc_q.delete();
    n_done = 0; done_cyc = -1; bp_err = 0; hold_err = 0; stall_cnt = 0;
    timed_out = 1'b0;
    @(posedge clk); #1;
    start = 1'b1; map_w = 7'(w); map_h = 7'(h); pool_en = pool;
    @(posedge clk); #1;
    start = 1'b0;
    check("busy_rise", longint'(busy), 1);
    idx = 0; cyc_i = 0; prev_stall = 1'b0; prev_data = '0;
    while (1) begin
      in_valid  = (idx < n);
      in_data   = (idx < n) ? 32'(vals[idx]) : 32'd0;
      out_ready = bp ? cyc_i[0] : 1'b1;
      @(negedge clk);
      if (prev_stall && !(out_valid && out_data == prev_data)) hold_err++;
      if (out_valid && !out_ready && in_ready) bp_err++;
      if (out_valid && !out_ready) stall_cnt++;
      if (in_valid && in_ready) begin
        acc_cyc_q.push_back(cyc_i);
        idx++;
      end
      if (out_valid && out_ready) begin
        got_q.push_back(longint'($signed(out_data)));
        out_cyc_q.push_back(cyc_i);
      end
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
      if (done) begin
        n_done++;
        done_cyc = cyc_i;
      end
      @(posedge clk); #1;
      cyc_i++;
      if (n_done != 0) break;
      if (cyc_i > 1000) begin
        timed_out = 1'b1;
        break;
      end
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    check("timeout", longint'(timed_out), 0);
    check("busy_fall", longint'(busy), 0);
    check("done_width", longint'(done), 0);
  endtask

  task automatic check_outputs(input string tag);
    check({tag, "_out_count"}, longint'(got_q.size()), longint'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++)
      check($sformatf("%s_out%0d", tag, i),
            (i < got_q.size()) ? got_q[i] : 64'sh7fff_ffff_ffff, exp_q[i]);
  endtask

  initial begin
    int acc6;
    rst = 1'b0; start = 1'b0; map_w = '0; map_h = '0; pool_en = 1'b0;
    in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", longint'(in_ready), 0);
    check("rst_out_valid", longint'(out_valid), 0);
    check("rst_busy", longint'(busy), 0);
    check("rst_done", longint'(done), 0);
    check("rst_out_data", longint'(out_data), 0);
    @(negedge clk);
    rst = 1'b1;

    // Basic 4x4 pool
    vals.delete();
    for (int i = 0; i < 16; i++) vals.push_back(i);
    exp_q = '{5, 7, 13, 15};
    run_tile(4, 4, 1'b1, 1'b0);
    check_outputs("pool4");
    check("pool4_accepts", longint'(acc_cyc_q.size()), 16);
    check("pool4_done_cnt", longint'(n_done), 1);
    check("pool4_done_cyc", longint'(done_cyc), 16);
    check("pool4_done_after_last_out", longint'(done_cyc),
          longint'(out_cyc_q.size() > 0 ? out_cyc_q[out_cyc_q.size()-1] : -9) );

    // Signed 2x2
    vals = '{-8, -3, -5, -9};
    exp_q = '{-3};
    run_tile(2, 2, 1'b1, 1'b0);
    check_outputs("signed2");
    check("signed2_done_cnt", longint'(n_done), 1);

    // Odd 5x5 pool: last row and column discarded
    vals.delete();
    for (int i = 0; i < 25; i++) vals.push_back(i);
    exp_q = '{6, 8, 16, 18};
    run_tile(5, 5, 1'b1, 1'b0);
    check_outputs("odd5");
    check("odd5_accepts", longint'(acc_cyc_q.size()), 25);
    check("odd5_done_cyc", longint'(done_cyc),
          longint'(acc_cyc_q.size() > 0 ? acc_cyc_q[acc_cyc_q.size()-1] + 1 : -9));

    // Backpressure 4x4 pool
    vals.delete();
    for (int i = 0; i < 16; i++) vals.push_back(i);
    exp_q = '{5, 7, 13, 15};
    run_tile(4, 4, 1'b1, 1'b1);
    check_outputs("bp4");
    check("bp4_accepts", longint'(acc_cyc_q.size()), 16);
    check("bp4_in_ready_drop", longint'(bp_err), 0);
    check("bp4_hold_stable", longint'(hold_err), 0);
    check("bp4_stalls_seen", longint'(stall_cnt > 0), 1);
    check("bp4_done_cnt", longint'(n_done), 1);

    // Bypass 3x3
    vals.delete();
    for (int i = 0; i < 9; i++) vals.push_back(100 + i);
    exp_q.delete();
    for (int i = 0; i < 9; i++) exp_q.push_back(100 + i);
    run_tile(3, 3, 1'b0, 1'b0);
    check_outputs("byp3");
    for (int i = 0; i < 9; i++)
      check($sformatf("byp3_lat%0d", i),
            (i < out_cyc_q.size() && i < acc_cyc_q.size()) ? longint'(out_cyc_q[i] - acc_cyc_q[i]) : -1,
            1);
    check("byp3_done_cnt", longint'(n_done), 1);

    // Reset after the 6th pixel of a 4x4 pool tile
    vals.delete();
    for (int i = 0; i < 16; i++) vals.push_back(i);
    @(posedge clk); #1;
    start = 1'b1; map_w = 7'd4; map_h = 7'd4; pool_en = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    n_done = 0; acc6 = 0;
    for (int c = 0; c < 20 && acc6 < 6; c++) begin
      in_valid = 1'b1;
      in_data  = 32'(vals[acc6]);
      @(negedge clk);
      if (in_ready) acc6++;
      if (done) n_done++;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    check("mid_accepts", longint'(acc6), 6);
    check("mid_out_valid_pre", longint'(out_valid), 1);
    check("mid_out_data_pre", longint'($signed(out_data)), 5);
    rst = 1'b0;
    #1;
    check("mid_rst_in_ready", longint'(in_ready), 0);
    check("mid_rst_out_valid", longint'(out_valid), 0);
    check("mid_rst_busy", longint'(busy), 0);
    check("mid_rst_out_data", longint'(out_data), 0);
    repeat (2) begin
      @(negedge clk);
      if (done) n_done++;
    end
    check("mid_no_done", longint'(n_done), 0);
    rst = 1'b1;
    exp_q = '{5, 7, 13, 15};
    run_tile(4, 4, 1'b1, 1'b0);
    check_outputs("after_rst");
    check("after_rst_done_cnt", longint'(n_done), 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
